// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues sequential word reads to
// instruction memory, buffers returned words with their PCs in a small FIFO and
// hands them to the core over valid/ready. A redirect flushes the FIFO and
// discards every response still in flight.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;

    logic [31:0] pc_mem   [DEPTH];
    logic [31:0] word_mem [DEPTH];

    logic [CW:0] credit_used;
    logic        accept;
    logic        push;
    logic        pop;

    // A request is only issued when a FIFO slot is guaranteed for its response,
    // so the memory side never needs backpressure.
    assign credit_used = {1'b0, count_q} + {1'b0, outstanding_q};
    assign imem_req    = !rst && !redirect && (credit_used < (CW+1)'(DEPTH));
    assign imem_addr   = fetch_pc_q;
    assign accept      = imem_req && imem_ready;

    // Redirect kills any same-cycle push or pop.
    assign push = imem_rvalid && (drop_cnt_q == '0) && !redirect;
    assign pop  = instr_valid && instr_ready && !redirect;

    // Head of FIFO drives the core; outputs are zeroed while empty.
    always_comb begin
        instr_valid = (count_q != '0);
        instr       = '0;
        instr_pc    = '0;
        if (instr_valid) begin
            instr    = word_mem[rd_ptr_q];
            instr_pc = pc_mem[rd_ptr_q];
        end
    end

    // Next-state for PCs, credit counters and FIFO pointers; redirect overrides.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        outstanding_d = outstanding_q + CW'(accept) - CW'(imem_rvalid);
        drop_cnt_d    = drop_cnt_q;
        count_d       = count_q + CW'(push) - CW'(pop);
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;

        if (accept) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
        if (imem_rvalid && (drop_cnt_q != '0)) begin
            drop_cnt_d = drop_cnt_q - CW'(1);
        end
        if (push) begin
            resp_pc_d = resp_pc_q + 32'd4;
            wr_ptr_d  = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        if (redirect) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            resp_pc_d  = {redirect_pc[31:2], 2'b00};
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            // The response arriving this cycle is dropped on the spot.
            drop_cnt_d = outstanding_q - CW'(imem_rvalid);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
        end
    end

    // FIFO storage; contents are don't-care until count marks them valid.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q]   <= resp_pc_q;
            word_mem[wr_ptr_q] <= imem_rdata;
        end
    end

endmodule
